// File: rtl/mem_bus_fabric_if.sv
// Native picorv32 memory bus plus per-slot slave-side signals.
// The "slave" modport is taken by the fabric; "master" drives it from the CPU/slave side.
interface mem_bus_fabric_if #(
    parameter int unsigned NUM_SLOTS = 4
);
    logic                     mem_valid;
    logic [31:0]              mem_addr;
    logic [3:0]               mem_wstrb;
    logic                     mem_ready;
    logic [31:0]              mem_rdata;
    logic [NUM_SLOTS-1:0]     s_sel;
    logic [4*NUM_SLOTS-1:0]   s_we;
    logic [32*NUM_SLOTS-1:0]  s_rdata;
    logic [NUM_SLOTS-1:0]     s_ready;
    logic                     bus_err;
    logic [31:0]              err_addr;

    modport slave (
        input  mem_valid, mem_addr, mem_wstrb, s_rdata, s_ready,
        output mem_ready, mem_rdata, s_sel, s_we, bus_err, err_addr
    );

    modport master (
        output mem_valid, mem_addr, mem_wstrb, s_rdata, s_ready,
        input  mem_ready, mem_rdata, s_sel, s_we, bus_err, err_addr
    );
endinterface

// File: rtl/mem_bus_fabric.sv
// Address-decoding interconnect for the picorv32 native bus: per-slot selects,
// fixed or slave-driven completion with timeout, and error completion for unmapped/timed-out accesses.
module mem_bus_fabric #(
    parameter int unsigned            NUM_SLOTS   = 4,
    parameter int unsigned            SLOT_LSB    = 12,
    parameter int unsigned            SLOT_BITS   = 4,
    parameter logic [4*NUM_SLOTS-1:0] WAIT_STATES = 16'h1111,
    parameter logic [NUM_SLOTS-1:0]   EXT_READY   = '0,
    parameter logic [7:0]             TIMEOUT     = 8'd255,
    parameter logic [31:0]            ERR_DATA    = 32'hDEADBEEF
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_bus_fabric_if.slave   bus
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e                 state_q, state_d;
    logic [NUM_SLOTS-1:0]   sel_q, sel_d;
    logic                   ext_q, ext_d;
    logic                   err_q, err_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [31:0]            addr_q, addr_d;
    logic [31:0]            err_addr_q, err_addr_d;

    logic [SLOT_BITS-1:0]   idx;
    logic                   upper_zero;
    logic                   hit;
    logic [NUM_SLOTS-1:0]   dec_onehot;
    logic [3:0]             dec_wait;
    logic [3:0]             wait_eff;
    logic                   dec_ext;
    logic                   dec_rdy;
    logic                   lat_rdy;
    logic [31:0]            lat_rdata;
    logic [NUM_SLOTS-1:0]   s_sel_c;
    logic [4*NUM_SLOTS-1:0] s_we_c;

    assign idx        = bus.mem_addr[SLOT_LSB +: SLOT_BITS];
    assign upper_zero = (bus.mem_addr >> (SLOT_LSB + SLOT_BITS)) == 32'd0;

    // Decode the incoming address, and separately mux the slot latched for the access in flight.
    always_comb begin
        dec_onehot = '0;
        dec_wait   = 4'd1;
        dec_ext    = 1'b0;
        dec_rdy    = 1'b0;
        lat_rdy    = 1'b0;
        lat_rdata  = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (idx == SLOT_BITS'(i)) begin
                dec_onehot[i] = 1'b1;
                dec_wait      = WAIT_STATES[4*i +: 4];
                dec_ext       = EXT_READY[i];
                dec_rdy       = bus.s_ready[i];
            end
            if (sel_q[i]) begin
                lat_rdy   = bus.s_ready[i];
                lat_rdata = bus.s_rdata[32*i +: 32];
            end
        end
    end

    assign hit      = upper_zero & (|dec_onehot);
    assign wait_eff = (dec_wait == 4'd0) ? 4'd1 : dec_wait;

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        ext_d      = ext_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        err_addr_d = err_addr_q;
        case (state_q)
            S_IDLE: begin
                if (bus.mem_valid) begin
                    addr_d = bus.mem_addr;
                    sel_d  = hit ? dec_onehot : '0;
                    ext_d  = hit & dec_ext;
                    err_d  = 1'b0;
                    if (!hit) begin
                        err_d      = 1'b1;
                        err_addr_d = bus.mem_addr;
                        state_d    = S_RESP;
                    end else if (dec_ext) begin
                        if (dec_rdy) begin
                            state_d = S_RESP;
                        end else if (TIMEOUT <= 8'd1) begin
                            err_d      = 1'b1;
                            err_addr_d = bus.mem_addr;
                            state_d    = S_RESP;
                        end else begin
                            cnt_d   = TIMEOUT - 8'd1;
                            state_d = S_WAIT;
                        end
                    end else if (wait_eff == 4'd1) begin
                        state_d = S_RESP;
                    end else begin
                        cnt_d   = {4'd0, wait_eff} - 8'd1;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // Timeout fires on the last sample without s_ready, so completion lands at T0+TIMEOUT.
                if (ext_q && lat_rdy) begin
                    state_d = S_RESP;
                end else if (cnt_q <= 8'd1) begin
                    state_d = S_RESP;
                    if (ext_q) begin
                        err_d      = 1'b1;
                        err_addr_d = addr_q;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        s_sel_c = '0;
        s_we_c  = '0;
        if (rst_n) begin
            if (state_q == S_IDLE) begin
                if (bus.mem_valid && hit) begin
                    s_sel_c = dec_onehot;
                    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                        if (dec_onehot[i]) s_we_c[4*i +: 4] = bus.mem_wstrb;
                    end
                end
            end else begin
                s_sel_c = sel_q;
            end
        end
    end

    assign bus.s_sel     = s_sel_c;
    assign bus.s_we      = s_we_c;
    assign bus.mem_ready = (state_q == S_RESP);
    assign bus.bus_err   = (state_q == S_RESP) && err_q;
    assign bus.mem_rdata = (state_q != S_RESP) ? '0 : (err_q ? ERR_DATA : lat_rdata);
    assign bus.err_addr  = err_addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            sel_q      <= '0;
            ext_q      <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            addr_q     <= '0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            ext_q      <= ext_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            err_addr_q <= err_addr_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_fabric.sv
// Randomized self-checking bench for mem_bus_fabric; expectations come from an
// access-level model (slot table, latency rule, error rule) kept here.
module tb_mem_bus_fabric;

    localparam int          NS   = 5;
    localparam int          TMO  = 8;
    localparam logic [31:0] ERRW = 32'hDEADBEEF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_bus_fabric_if #(.NUM_SLOTS(NS)) bus ();

    mem_bus_fabric #(
        .NUM_SLOTS   (NS),
        .SLOT_LSB    (12),
        .SLOT_BITS   (4),
        .WAIT_STATES (20'h5F310),
        .EXT_READY   (5'b01000),
        .TIMEOUT     (8'(TMO)),
        .ERR_DATA    (ERRW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Slot map: configured wait states (0 means 1) and which slot is slave-timed.
    int wait_cfg[NS] = '{0, 1, 3, 15, 5};
    bit ext_cfg[NS]  = '{0, 0, 0, 1, 0};

    int          total = 0;
    int          bad   = 0;
    logic [31:0] model_err_addr = '0;

    // d = cycle offset from T0 at which the slave raises s_ready (slave-timed slots only).
    task automatic run_access(input logic [31:0] addr, input logic [3:0] wstrb,
                              input int d, input bit drop_valid, input string tag);
        int                slot;
        bit                mapped;
        bit                exp_err;
        int                lat;
        logic [31:0]       exp_rdata;
        logic [NS-1:0]     exp_sel;
        logic [4*NS-1:0]   exp_we;
        logic [NS-1:0]     rdy;
        logic [4*NS-1:0]   we_now;
        slot   = int'(addr[15:12]);
        mapped = (addr[31:16] == 16'h0) && (slot < NS);
        for (int i = 0; i < NS; i++) bus.s_rdata[32*i +: 32] = $urandom;
        exp_sel = '0;
        exp_we  = '0;
        if (!mapped) begin
            lat = 1; exp_err = 1'b1;
        end else if (ext_cfg[slot]) begin
            if (d < TMO) begin lat = d + 1; exp_err = 1'b0; end
            else begin lat = TMO; exp_err = 1'b1; end
        end else begin
            lat = (wait_cfg[slot] == 0) ? 1 : wait_cfg[slot];
            exp_err = 1'b0;
        end
        if (mapped) begin
            exp_sel[slot]        = 1'b1;
            exp_we[4*slot +: 4]  = wstrb;
        end
        exp_rdata = exp_err ? ERRW : (mapped ? bus.s_rdata[32*slot +: 32] : 32'h0);
        if (exp_err) model_err_addr = addr;

        bus.mem_valid = 1'b1;
        bus.mem_addr  = addr;
        bus.mem_wstrb = wstrb;
        for (int k = 0; k <= lat; k++) begin
            rdy = NS'($urandom);
            if (mapped && ext_cfg[slot]) rdy[slot] = (k == d);
            bus.s_ready = rdy;
            @(negedge clk);
            we_now = (k == 0) ? exp_we : '0;
            total++;
            if (bus.mem_ready !== (k == lat))
                $display("FAIL %s ready k=%0d got=%b exp=%b", tag, k, bus.mem_ready, (k == lat));
            if (bus.mem_ready !== (k == lat)) bad++;
            total++;
            if (bus.s_sel !== exp_sel) begin
                bad++;
                $display("FAIL %s s_sel k=%0d got=%b exp=%b", tag, k, bus.s_sel, exp_sel);
            end
            total++;
            if (bus.s_we !== we_now) begin
                bad++;
                $display("FAIL %s s_we k=%0d got=%h exp=%h", tag, k, bus.s_we, we_now);
            end
            total++;
            if (bus.bus_err !== ((k == lat) && exp_err)) begin
                bad++;
                $display("FAIL %s bus_err k=%0d got=%b exp=%b", tag, k, bus.bus_err, ((k == lat) && exp_err));
            end
            total++;
            if (bus.mem_rdata !== ((k == lat) ? exp_rdata : 32'h0)) begin
                bad++;
                $display("FAIL %s rdata k=%0d got=%h exp=%h", tag, k, bus.mem_rdata,
                         ((k == lat) ? exp_rdata : 32'h0));
            end
            if (k == lat) begin
                total++;
                if (bus.err_addr !== model_err_addr) begin
                    bad++;
                    $display("FAIL %s err_addr got=%h exp=%h", tag, bus.err_addr, model_err_addr);
                end
            end
            @(posedge clk); #1;
            if (drop_valid) bus.mem_valid = 1'b0;
        end
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = 4'h0;
        bus.s_ready   = '0;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            bus.s_ready = NS'($urandom);
            @(negedge clk);
            total++;
            if (bus.mem_ready !== 1'b0 || bus.s_sel !== '0) begin
                bad++;
                $display("FAIL idle ready/sel got=%b/%b exp=0/0", bus.mem_ready, bus.s_sel);
            end
            @(posedge clk); #1;
        end
        bus.s_ready = '0;
    endtask

    task automatic test_reset();
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 32'h0000_1000;
        bus.mem_wstrb = 4'hF;
        bus.s_ready   = '1;
        bus.s_rdata   = {NS{32'hA5A5_5A5A}};
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            total++;
            if (bus.mem_ready !== 1'b0) begin bad++; $display("FAIL rst ready got=%b exp=0", bus.mem_ready); end
            total++;
            if (bus.s_sel !== '0) begin bad++; $display("FAIL rst s_sel got=%b exp=0", bus.s_sel); end
            total++;
            if (bus.s_we !== '0) begin bad++; $display("FAIL rst s_we got=%h exp=0", bus.s_we); end
            total++;
            if (bus.bus_err !== 1'b0) begin bad++; $display("FAIL rst bus_err got=%b exp=0", bus.bus_err); end
            total++;
            if (bus.err_addr !== 32'h0) begin bad++; $display("FAIL rst err_addr got=%h exp=0", bus.err_addr); end
            total++;
            if (bus.mem_rdata !== 32'h0) begin bad++; $display("FAIL rst rdata got=%h exp=0", bus.mem_rdata); end
        end
        @(posedge clk); #1;
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = 4'h0;
        bus.s_ready   = '0;
        rst_n = 1'b1;
        idle_cycles(2);
    endtask

    task automatic test_directed();
        run_access(32'h0000_1004, 4'b0000, 0,   0, "rd_slot1");
        run_access(32'h0000_2010, 4'b0011, 0,   1, "wr_slot2");
        run_access(32'h0000_3000, 4'b0000, 5,   0, "ext_rdy5");
        run_access(32'h0000_3ABC, 4'b1111, 100, 0, "ext_timeout");
        run_access(32'h0000_7000, 4'b0000, 0,   0, "unmap_idx7");
        run_access(32'h0001_0000, 4'b1111, 0,   0, "unmap_upper");
        run_access(32'h0000_0FFC, 4'b0000, 0,   0, "slot0_w0");
        run_access(32'h0000_4000, 4'b1000, 0,   1, "slot4_w5");
        run_access(32'h0000_3004, 4'b0000, 0,   0, "ext_rdy_t0");
        run_access(32'h0000_3008, 4'b0101, 7,   0, "ext_rdy_last");
        run_access(32'h0000_300C, 4'b0000, 8,   0, "ext_rdy_late");
        idle_cycles(1);
    endtask

    task automatic test_back_to_back();
        run_access(32'h0000_1100, 4'b0000, 0, 0, "b2b_a");
        run_access(32'h0000_5000, 4'b0000, 0, 0, "b2b_unmap");
        run_access(32'h0000_3100, 4'b0000, 2, 0, "b2b_ext");
        run_access(32'h0000_2200, 4'b1100, 0, 0, "b2b_w3");
        idle_cycles(1);
    endtask

    task automatic test_random();
        logic [3:0]  sv;
        logic [31:0] a;
        logic [3:0]  ws;
        for (int n = 0; n < 60; n++) begin
            sv = 4'($urandom_range(0, 7));
            a  = {16'h0, sv, 12'($urandom)};
            if ($urandom_range(0, 4) == 0) a[31:16] = 16'($urandom_range(1, 65535));
            ws = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
            run_access(a, ws, int'($urandom_range(0, 10)), 1'($urandom_range(0, 1)), "rand");
            if ($urandom_range(0, 2) == 0) idle_cycles(int'($urandom_range(1, 3)));
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < NS; i++) bus.s_rdata[32*i +: 32] = $urandom;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 32'h0000_4008;
        bus.mem_wstrb = 4'h0;
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst_n = 1'b0;
        model_err_addr = '0;
        #1;
        total++;
        if (bus.mem_ready !== 1'b0) begin bad++; $display("FAIL midrst ready got=%b exp=0", bus.mem_ready); end
        total++;
        if (bus.s_sel !== '0) begin bad++; $display("FAIL midrst s_sel got=%b exp=0", bus.s_sel); end
        total++;
        if (bus.s_we !== '0) begin bad++; $display("FAIL midrst s_we got=%h exp=0", bus.s_we); end
        total++;
        if (bus.bus_err !== 1'b0) begin bad++; $display("FAIL midrst bus_err got=%b exp=0", bus.bus_err); end
        total++;
        if (bus.err_addr !== model_err_addr) begin bad++; $display("FAIL midrst err_addr got=%h exp=%h", bus.err_addr, model_err_addr); end
        total++;
        if (bus.mem_rdata !== 32'h0) begin bad++; $display("FAIL midrst rdata got=%h exp=0", bus.mem_rdata); end
        repeat (4) begin
            @(negedge clk);
            total++;
            if (bus.mem_ready !== 1'b0 || bus.s_sel !== '0) begin
                bad++;
                $display("FAIL midrst hold ready/sel got=%b/%b exp=0/0", bus.mem_ready, bus.s_sel);
            end
        end
        @(posedge clk); #1;
        bus.mem_valid = 1'b0;
        rst_n = 1'b1;
        idle_cycles(6);
        run_access(32'h0000_1008, 4'b0000, 0, 0, "post_reset_rd");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
